riscv_result_checker: RTL and testbench

RISCV_RESULT_CHECKER -- requirements
Module: riscv_result_checker

---
 rtl/riscv_chk_pkg.sv | 21 ++
 rtl/riscv_chk_cmp.sv | 17 +
 rtl/riscv_result_checker.sv | 145 ++++++++++++++
 tb/tb_riscv_result_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_chk_pkg.sv
// Shared types and width constants for the RISC-V result checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_chk_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int CYCLE_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } chk_state_t;

    // Bits needed for a counter running 0 .. n-1 (never narrower than 1).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/riscv_chk_cmp.sv
// One channel's masked equality compare: match when disabled or obs equals exp.
// Latency: combinational.
// Backpressure: none.
module riscv_chk_cmp
    import riscv_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              en,
    input  logic [DATA_W-1:0] obs,
    input  logic [DATA_W-1:0] exp,
    output logic              match
);

    assign match = !en || (obs == exp);

endmodule

// File: rtl/riscv_result_checker.sv
// Watches NUM_CH observed/expected channel pairs after a start pulse and reports pass/fail.
// Latency: SETTLE_CYCLES + STABLE_CYCLES to pass (1 CHECK cycle without RESULT_CHK_STABLE_EN), else timeout.
// Backpressure: none; start is ignored while busy. Build macro: RESULT_CHK_STABLE_EN.
module riscv_result_checker
    import riscv_chk_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STABLE_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] obs_data,
    input  logic [NUM_CH*DATA_W-1:0] exp_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [NUM_CH-1:0]        fail_mask,
    output logic [CYCLE_CNT_W-1:0]   cycle_count
);

    localparam int SET_W = cnt_w(SETTLE_CYCLES);
    localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    chk_state_t        state_q, state_d;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [TO_W-1:0]   chk_cnt_q;
    logic [NUM_CH-1:0] ch_match;
    logic              all_match;
    logic              settle_last;
    logic              timeout_hit;
    logic              pass_hit;
    logic              accept_start;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        riscv_chk_cmp #(
            .DATA_W (DATA_W)
        ) u_cmp (
            .en    (ch_mask[g]),
            .obs   (obs_data[g*DATA_W +: DATA_W]),
            .exp   (exp_data[g*DATA_W +: DATA_W]),
            .match (ch_match[g])
        );
    end

    assign all_match    = &ch_match;
    assign settle_last  = (SETTLE_CYCLES <= 1) || (settle_cnt_q == SETTLE_LAST);
    assign timeout_hit  = (TIMEOUT_CYCLES <= 1) || (chk_cnt_q == TO_LAST);
    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef RESULT_CHK_STABLE_EN
    localparam int STAB_W = cnt_w(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [STAB_W-1:0] stab_cnt_q;

    assign pass_hit = all_match && ((STABLE_CYCLES <= 1) || (stab_cnt_q == STAB_LAST));

    // Counts consecutive full-match CHECK cycles; any mismatch or leaving CHECK restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_cnt_q <= '0;
        end else if ((state_q == ST_CHECK) && all_match && !pass_hit) begin
            stab_cnt_q <= stab_cnt_q + 1'b1;
        end else begin
            stab_cnt_q <= '0;
        end
    end
`else
    // STABLE_CYCLES has no effect in this build: the first full-match cycle passes.
    assign pass_hit = all_match && (STABLE_CYCLES >= 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pass_hit || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt_q <= '0;
            chk_cnt_q    <= '0;
            cycle_count  <= '0;
            pass         <= 1'b0;
            fail_mask    <= '0;
        end else if (accept_start) begin
            settle_cnt_q <= '0;
            chk_cnt_q    <= '0;
            cycle_count  <= '0;
            pass         <= 1'b0;
            fail_mask    <= '0;
        end else if ((state_q == ST_SETTLE) || (state_q == ST_CHECK)) begin
            if (!(&cycle_count)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (state_q == ST_SETTLE) begin
                settle_cnt_q <= settle_cnt_q + 1'b1;
            end else begin
                chk_cnt_q <= chk_cnt_q + 1'b1;
                // A pass on the timeout cycle takes priority over the failure report.
                if (pass_hit) begin
                    pass      <= 1'b1;
                    fail_mask <= '0;
                end else if (timeout_hit) begin
                    fail_mask <= ~ch_match;
                end
            end
        end
    end

    assign busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_riscv_result_checker.sv
// Scoreboard bench for riscv_result_checker: runs push expected results, a monitor checks on done.
module tb_riscv_result_checker;

`ifdef RESULT_CHK_STABLE_EN
    localparam bit STAB_BUILD = 1'b1;
`else
    localparam bit STAB_BUILD = 1'b0;
`endif
    // Hand-derived: 3 settle cycles, then 2 stable cycles (or 1 cycle in the non-stable build).
    localparam int EXP_PASS_CC = STAB_BUILD ? 5 : 4;
    localparam int EXP_TO_CC   = 67;

    typedef struct packed {
        logic        p;
        logic [3:0]  fm;
        logic [31:0] cc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   ch_mask;
    logic [127:0] obs_data;
    logic [127:0] exp_data;
    logic         busy;
    logic         done;
    logic         pass;
    logic [3:0]   fail_mask;
    logic [31:0]  cycle_count;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;
    bit   stim_done;

    riscv_result_checker dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ch_mask     (ch_mask),
        .obs_data    (obs_data),
        .exp_data    (exp_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_mask   (fail_mask),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic push_exp(input logic p, input logic [3:0] fm, input int cc);
        exp_t e;
        e.p  = p;
        e.fm = fm;
        e.cc = 32'(cc);
        sb_q.push_back(e);
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic monitor();
        logic done_q = 1'b0;
        int   run    = 0;
        exp_t e;
        while (!stim_done) begin
            @(negedge clk);
            if (done && !done_q) begin
                run++;
                if (sb_q.size() == 0) begin
                    chk($sformatf("run%0d_unexpected_done", run), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("run%0d_pass", run), 32'(pass), 32'(e.p));
                    chk($sformatf("run%0d_fail_mask", run), 32'(fail_mask), 32'(e.fm));
                    chk($sformatf("run%0d_cycle_count", run), cycle_count, e.cc);
                end
            end
            done_q = done;
        end
    endtask

    task automatic stimulus();
        exp_data = {32'hDEAD_0003, 32'h0000_0007, 32'hCAFE_0001, 32'h1234_5678};
        obs_data = exp_data;
        ch_mask  = 4'b1111;
        start    = 1'b0;
        reset    = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_mask", 32'(fail_mask), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        #10;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // All channels match from the first cycle.
        launch();
        chk("r1_busy_after_start", 32'(busy), 32'd1);
        chk("r1_cc_after_start", cycle_count, 32'd0);
        push_exp(1'b1, 4'b0000, EXP_PASS_CC);
        wait_done("r1");

        // Channel 2 stuck mismatching: timeout.
        obs_data[64 +: 32] = 32'd5;
        launch();
        push_exp(1'b0, 4'b0100, EXP_TO_CC);
        wait_done("r2");
        repeat (3) @(posedge clk);
        #1;
        chk("r2_cc_frozen", cycle_count, 32'(EXP_TO_CC));
        chk("r2_fm_frozen", 32'(fail_mask), 32'h4);

        // Same mismatch but channel 2 masked off; restarted straight from DONE.
        ch_mask = 4'b1011;
        launch();
        chk("r3_done_cleared", 32'(done), 32'd0);
        chk("r3_fm_cleared", 32'(fail_mask), 32'd0);
        chk("r3_cc_cleared", cycle_count, 32'd0);
        push_exp(1'b1, 4'b0000, EXP_PASS_CC);
        wait_done("r3");

        // Channel 0 alternates match/mismatch; CHECK cycles at even edges match.
        ch_mask  = 4'b1111;
        obs_data = exp_data;
        obs_data[0 +: 32] = 32'h0BAD_0BAD;
        launch();
        if (STAB_BUILD) push_exp(1'b0, 4'b0001, EXP_TO_CC);
        else            push_exp(1'b1, 4'b0000, 4);
        for (int k = 0; k < 120 && !done; k++) begin
            obs_data[0 +: 32] = (((k + 1) % 2) == 0) ? exp_data[0 +: 32] : 32'h0BAD_0BAD;
            @(posedge clk); #1;
        end
        wait_done("r4");

        // Reset in the middle of a run that would otherwise time out.
        obs_data = exp_data;
        obs_data[32 +: 32] = 32'h0;
        launch();
        repeat (4) @(posedge clk);
        #1;
        chk("r5_cc_before_reset", cycle_count, 32'd4);
        reset = 1'b0;
        #1;
        chk("r5_rst_busy", 32'(busy), 32'd0);
        chk("r5_rst_done", 32'(done), 32'd0);
        chk("r5_rst_pass", 32'(pass), 32'd0);
        chk("r5_rst_fail_mask", 32'(fail_mask), 32'd0);
        chk("r5_rst_cycle_count", cycle_count, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("r5_idle_after_release", 32'(busy), 32'd0);
        obs_data = exp_data;
        launch();
        chk("r6_cc_restart", cycle_count, 32'd0);
        push_exp(1'b1, 4'b0000, EXP_PASS_CC);
        wait_done("r6");

        // Start pulses during SETTLE and CHECK are ignored.
        launch();
        push_exp(1'b1, 4'b0000, EXP_PASS_CC);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("r7_cc_after_settle_start", cycle_count, 32'd2);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("r7_cc_after_check_start", cycle_count, 32'd4);
        wait_done("r7");

        // Restart from a passing DONE clears pass.
        obs_data[96 +: 32] = 32'h0;
        launch();
        chk("r8_pass_cleared", 32'(pass), 32'd0);
        chk("r8_busy", 32'(busy), 32'd1);
        push_exp(1'b0, 4'b1000, EXP_TO_CC);
        wait_done("r8");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        stim_done = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        stim_done = 1'b0;
        fork
            monitor();
            stimulus();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
